// File: rtl/mm_pkg.sv
// Shared constants, state encoding and width helper for the Mastermind scorer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mm_pkg;

  localparam int MM_NUM_PEGS = 4;
  localparam int MM_COLOR_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RED   = 2'd1,
    WHITE = 2'd2,
    DONE  = 2'd3
  } mm_state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int score_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mm_first_match.sv
// Finds the lowest unused guess peg whose colour equals the target colour.
// Latency: combinational.
// Backpressure: none; result follows inputs.
module mm_first_match
  import mm_pkg::*;
#(
  parameter int NUM_PEGS = MM_NUM_PEGS,
  parameter int COLOR_W  = MM_COLOR_W,
  parameter int IDX_W    = $clog2(NUM_PEGS)
) (
  input  logic [COLOR_W-1:0]          i_color,
  input  logic [NUM_PEGS*COLOR_W-1:0] i_guess,
  input  logic [NUM_PEGS-1:0]         i_used,
  output logic                        o_found,
  output logic [IDX_W-1:0]            o_idx
);

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int j = NUM_PEGS - 1; j >= 0; j--) begin
      if (!i_used[j] && (i_guess[j*COLOR_W +: COLOR_W] == i_color)) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mm_peg_scorer.sv
// Scores a guess against a secret code (red/white pegs), one peg per cycle.
// Latency: done 2*NUM_PEGS+1 cycles after accepted start (NUM_PEGS+1 on an early win).
// Backpressure: start is ignored while busy; optional win/early exit under MM_SCORE_EARLY_WIN_EN.
module mm_peg_scorer
  import mm_pkg::*;
#(
  parameter int  NUM_PEGS = MM_NUM_PEGS,
  parameter int  COLOR_W  = MM_COLOR_W,
  localparam int SCORE_W  = score_width(NUM_PEGS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_PEGS*COLOR_W-1:0] code,
  input  logic [NUM_PEGS*COLOR_W-1:0] guess,
  output logic                        busy,
  output logic                        done,
  output logic [SCORE_W-1:0]          red,
  output logic [SCORE_W-1:0]          white
`ifdef MM_SCORE_EARLY_WIN_EN
  ,
  output logic                        win
`endif
);

  localparam int IDX_W = $clog2(NUM_PEGS);

  mm_state_t                   r_state;
  mm_state_t                   w_state_nxt;
  logic [NUM_PEGS*COLOR_W-1:0] r_code;
  logic [NUM_PEGS*COLOR_W-1:0] r_guess;
  logic [NUM_PEGS-1:0]         r_code_used;
  logic [NUM_PEGS-1:0]         r_guess_used;
  logic [IDX_W-1:0]            r_idx;
  logic [SCORE_W-1:0]          r_red_cnt;
  logic [SCORE_W-1:0]          r_white_cnt;
  logic [SCORE_W-1:0]          r_red;
  logic [SCORE_W-1:0]          r_white;
  logic                        r_busy;
  logic                        r_done;
`ifdef MM_SCORE_EARLY_WIN_EN
  logic                        r_win;
`endif

  logic [COLOR_W-1:0]          w_code_peg;
  logic [COLOR_W-1:0]          w_guess_peg;
  logic                        w_last;
  logic                        w_red_hit;
  logic [SCORE_W-1:0]          w_red_sum;
  logic                        w_found;
  logic [IDX_W-1:0]            w_match_idx;

  assign w_code_peg  = r_code[int'(r_idx)*COLOR_W +: COLOR_W];
  assign w_guess_peg = r_guess[int'(r_idx)*COLOR_W +: COLOR_W];
  assign w_last      = (r_idx == IDX_W'(NUM_PEGS - 1));
  assign w_red_hit   = (w_code_peg == w_guess_peg);
  assign w_red_sum   = r_red_cnt + SCORE_W'(w_red_hit);

  // White pass: lowest still-unclaimed guess peg of the current code colour.
  mm_first_match #(
    .NUM_PEGS (NUM_PEGS),
    .COLOR_W  (COLOR_W),
    .IDX_W    (IDX_W)
  ) u_first_match (
    .i_color (w_code_peg),
    .i_guess (r_guess),
    .i_used  (r_guess_used),
    .o_found (w_found),
    .o_idx   (w_match_idx)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: exact-match pass, then cross-position pass, then one result cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = RED;
      RED: begin
        if (w_last) begin
`ifdef MM_SCORE_EARLY_WIN_EN
          w_state_nxt = (w_red_sum == SCORE_W'(NUM_PEGS)) ? DONE : WHITE;
`else
          w_state_nxt = WHITE;
`endif
        end
      end
      WHITE: if (w_last) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands, accumulate counts, publish results on DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_code       <= '0;
      r_guess      <= '0;
      r_code_used  <= '0;
      r_guess_used <= '0;
      r_idx        <= '0;
      r_red_cnt    <= '0;
      r_white_cnt  <= '0;
      r_red        <= '0;
      r_white      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef MM_SCORE_EARLY_WIN_EN
      r_win        <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_code       <= code;
            r_guess      <= guess;
            r_code_used  <= '0;
            r_guess_used <= '0;
            r_idx        <= '0;
            r_red_cnt    <= '0;
            r_white_cnt  <= '0;
            r_red        <= '0;
            r_white      <= '0;
            r_busy       <= 1'b1;
`ifdef MM_SCORE_EARLY_WIN_EN
            r_win        <= 1'b0;
`endif
          end
        end
        RED: begin
          r_red_cnt <= w_red_sum;
          if (w_red_hit) begin
            r_code_used[r_idx]  <= 1'b1;
            r_guess_used[r_idx] <= 1'b1;
          end
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        WHITE: begin
          if (!r_code_used[r_idx] && w_found) begin
            r_code_used[r_idx]        <= 1'b1;
            r_guess_used[w_match_idx] <= 1'b1;
            r_white_cnt               <= r_white_cnt + SCORE_W'(1);
          end
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        DONE: begin
          r_red   <= r_red_cnt;
          r_white <= r_white_cnt;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
`ifdef MM_SCORE_EARLY_WIN_EN
          r_win   <= (r_red_cnt == SCORE_W'(NUM_PEGS));
`endif
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign red   = r_red;
  assign white = r_white;
`ifdef MM_SCORE_EARLY_WIN_EN
  assign win   = r_win;
`endif

endmodule
